// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the message-schedule state encoding.
// Pure declarations: no latency, no flow control.
package sha256_pkg;
  localparam int DATA_WIDTH      = 32;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int ROUNDS          = 64;
  localparam int CNT_W           = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } sched_state_e;
endpackage

// File: rtl/msg_window.sv
// 16-word schedule window: indexed load, shift-by-one toward tap 0, taps 0/1/9/14.
// Writes land on the next clock edge; shift has priority, the caller never asserts both.
module msg_window
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [3:0]            load_idx,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] shift_word,
  output logic [DATA_WIDTH-1:0] tap0,
  output logic [DATA_WIDTH-1:0] tap1,
  output logic [DATA_WIDTH-1:0] tap9,
  output logic [DATA_WIDTH-1:0] tap14
);
  logic [WORDS_PER_BLOCK-1:0][DATA_WIDTH-1:0] win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) win[i] <= win[i+1];
      win[WORDS_PER_BLOCK-1] <= shift_word;
    end else if (load_en) begin
      win[load_idx] <= load_word;
    end
  end

  assign tap0  = win[0];
  assign tap1  = win[1];
  assign tap9  = win[9];
  assign tap14 = win[14];
endmodule

// File: rtl/sha256_sig.sv
// SHA-256 small sigma functions SIG0/SIG1 as combinational leaves.
// Zero latency, no flow control.
module sha256_sig0
  import sha256_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

module sha256_sig1
  import sha256_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: loads 16 words, streams W[0..63] at 1 word/cycle, S_w_ready_in low stalls in place.
// Outputs decode from registered state only; MSG_SCHED_ROUND_IDX_EN adds the D_t_out round index port.
module msg_schedule
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  S_start_in,
  input  logic [DATA_WIDTH-1:0] S_word_in,
  input  logic                  S_word_valid_in,
  output logic                  D_word_ready_out,
  output logic [DATA_WIDTH-1:0] D_w_out,
  output logic                  D_w_valid_out,
  input  logic                  S_w_ready_in,
`ifdef MSG_SCHED_ROUND_IDX_EN
  output logic [CNT_W-1:0]      D_t_out,
`endif
  output logic                  D_done_out
);
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] LAST_T    = CNT_W'(ROUNDS - 1);

  sched_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  load_en, shift_en;
  logic [DATA_WIDTH-1:0] w0, w1, w9, w14, s0, s1, w_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    load_en          = 1'b0;
    shift_en         = 1'b0;
    D_word_ready_out = 1'b0;
    D_w_valid_out    = 1'b0;
    D_done_out       = 1'b0;
    case (state_q)
      IDLE: begin
        if (S_start_in) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        D_word_ready_out = 1'b1;
        if (S_word_valid_in) begin
          load_en = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_LOAD) begin
            state_d = EXPAND;
            cnt_d   = '0;
          end
        end
      end
      EXPAND: begin
        D_w_valid_out = 1'b1;
        if (S_w_ready_in) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_T) state_d = DONE;
        end
      end
      DONE: begin
        D_done_out = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  msg_window u_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_idx   (cnt_q[3:0]),
    .load_word  (S_word_in),
    .shift_en   (shift_en),
    .shift_word (w_new),
    .tap0       (w0),
    .tap1       (w1),
    .tap9       (w9),
    .tap14      (w14)
  );

  sha256_sig0 u_sig0 (.x(w1),  .y(s0));
  sha256_sig1 u_sig1 (.x(w14), .y(s1));

  // Words produced past t=47 are never emitted, so the shift runs unguarded to the end.
  assign w_new   = s1 + w9 + s0 + w0;
  assign D_w_out = (state_q == EXPAND) ? w0 : '0;

`ifdef MSG_SCHED_ROUND_IDX_EN
  assign D_t_out = (state_q == EXPAND) ? cnt_q : '0;
`endif
endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: golden-word table plus stall, gap, reset-abort and back-to-back sequences.
module tb_msg_schedule;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        S_start_in;
  logic [31:0] S_word_in;
  logic        S_word_valid_in;
  logic        D_word_ready_out;
  logic [31:0] D_w_out;
  logic        D_w_valid_out;
  logic        S_w_ready_in;
`ifdef MSG_SCHED_ROUND_IDX_EN
  logic [5:0]  D_t_out;
`endif
  logic        D_done_out;

  msg_schedule dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .S_start_in       (S_start_in),
    .S_word_in        (S_word_in),
    .S_word_valid_in  (S_word_valid_in),
    .D_word_ready_out (D_word_ready_out),
    .D_w_out          (D_w_out),
    .D_w_valid_out    (D_w_valid_out),
    .S_w_ready_in     (S_w_ready_in),
`ifdef MSG_SCHED_ROUND_IDX_EN
    .D_t_out          (D_t_out),
`endif
    .D_done_out       (D_done_out)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] blk [16];
  logic [31:0] expw [64];
  logic [31:0] got [64];
  logic [31:0] got_abc [64];
  logic [31:0] got_ff [64];

  typedef struct {
    string       name;
    int          blk_id;
    int          t;
    logic [31:0] w;
  } gold_t;
  gold_t gold_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] f_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) expw[t] = blk[t];
      else expw[t] = f_sig1(expw[t-2]) + expw[t-7] + f_sig0(expw[t-15]) + expw[t-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_model();
  endtask

  task automatic set_ones();
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    build_model();
  endtask

  task automatic add_gold(input string name, input int id, input int t, input logic [31:0] w);
    gold_t g;
    g.name = name; g.blk_id = id; g.t = t; g.w = w;
    gold_q.push_back(g);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge after the 16th load.
  task automatic start_and_load(input int gap_at, input bit keep_start);
    int n; int guard; int gap; bit hs;
    n = 0; guard = 0; gap = 0;
    S_start_in = 1'b1;
    @(negedge clk);
    if (!keep_start) S_start_in = 1'b0;
    check1("start_latency_ready", D_word_ready_out, 1'b1);
    while (n < 16 && guard < 200) begin
      if (n == gap_at && gap < 3) begin
        S_word_valid_in = 1'b0;
        gap++;
      end else begin
        S_word_valid_in = 1'b1;
        S_word_in       = blk[n];
      end
      hs = S_word_valid_in && D_word_ready_out;
      @(negedge clk);
      guard++;
      if (hs) n++;
    end
    S_word_valid_in = 1'b0;
    check32("load_count", 32'(n), 32'd16);
  endtask

  // Drains schedule words into got[]; with abort_t >= 0 returns as soon as W[abort_t] is presented.
  task automatic collect(input bit stall, input int abort_t, output int nout);
    int guard; bit prev_stall; logic [31:0] prev_w;
    nout = 0; guard = 0; prev_stall = 1'b0; prev_w = '0;
    while (nout < 64 && guard < 4000) begin
      if (D_w_valid_out) begin
        if (prev_stall) check32($sformatf("stall_hold_t%0d", nout), D_w_out, prev_w);
        if (abort_t >= 0 && nout == abort_t) return;
        S_w_ready_in = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
        if (S_w_ready_in) begin
`ifdef MSG_SCHED_ROUND_IDX_EN
          check32($sformatf("t_index_%0d", nout), {26'b0, D_t_out}, 32'(nout));
`endif
          got[nout] = D_w_out;
          nout++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_w     = D_w_out;
        end
      end else begin
        prev_stall = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    S_w_ready_in = 1'b1;
  endtask

  task automatic compare_all(input string tag, input int nout);
    check32({tag, "_word_count"}, 32'(nout), 32'd64);
    for (int t = 0; t < 64; t++)
      check32($sformatf("%s_w%0d", tag, t), got[t], expw[t]);
  endtask

  // Entered at the negedge right after the final accept: DONE must be showing, then clear.
  task automatic check_done(input string tag);
    check1({tag, "_done_pulse"}, D_done_out, 1'b1);
    @(negedge clk);
    check1({tag, "_done_clear"}, D_done_out, 1'b0);
    check1({tag, "_valid_clear"}, D_w_valid_out, 1'b0);
    check1({tag, "_ready_idle"}, D_word_ready_out, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n; int t_start; int saw_done;
    rst_n = 1'b0; S_start_in = 1'b0; S_word_in = '0; S_word_valid_in = 1'b0; S_w_ready_in = 1'b1;

    add_gold("abc_w0",  0, 0,  32'h61626380);
    add_gold("abc_w1",  0, 1,  32'h00000000);
    add_gold("abc_w14", 0, 14, 32'h00000000);
    add_gold("abc_w15", 0, 15, 32'h00000018);
    add_gold("abc_w16", 0, 16, 32'h61626380);
    add_gold("abc_w17", 0, 17, 32'h000F0000);
    add_gold("abc_w18", 0, 18, 32'h7DA86405);
    add_gold("abc_w63", 0, 63, 32'h12B1EDEB);
    add_gold("ones_w0", 1, 0,  32'hFFFFFFFF);
    add_gold("ones_w16", 1, 16, 32'h203FFFFC);

    repeat (2) @(negedge clk);
    check32("rst_w_out", D_w_out, 32'h0);
    check1("rst_valid", D_w_valid_out, 1'b0);
    check1("rst_ready", D_word_ready_out, 1'b0);
    check1("rst_done", D_done_out, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check1("idle_no_start_ready", D_word_ready_out, 1'b0);

    // Plain abc block with the start-to-done cycle count.
    set_abc();
    t_start = ecnt;
    start_and_load(-1, 1'b0);
    check1("first_output_valid", D_w_valid_out, 1'b1);
    collect(1'b0, -1, n);
    check32("abc_done_cycle", 32'(ecnt - t_start + 1), 32'd82);
    compare_all("abc", n);
    for (int t = 0; t < 64; t++) got_abc[t] = got[t];
    check_done("abc");

    // Randomly stalled downstream.
    set_abc();
    start_and_load(-1, 1'b0);
    collect(1'b1, -1, n);
    compare_all("stall", n);
    check_done("stall");

    // Three idle cycles between words 7 and 8.
    set_abc();
    start_and_load(8, 1'b0);
    collect(1'b0, -1, n);
    compare_all("gap", n);
    check_done("gap");

    // Reset while W[30] is presented, then a clean block.
    set_abc();
    start_and_load(-1, 1'b0);
    collect(1'b0, 30, n);
    check32("abort_position", 32'(n), 32'd30);
    rst_n = 1'b0;
    #1;
    check32("abort_w_out", D_w_out, 32'h0);
    check1("abort_valid", D_w_valid_out, 1'b0);
    check1("abort_ready", D_word_ready_out, 1'b0);
    check1("abort_done", D_done_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (D_done_out || D_w_valid_out || D_word_ready_out) saw_done++;
    end
    check32("abort_stays_idle", 32'(saw_done), 32'd0);
    start_and_load(-1, 1'b0);
    collect(1'b0, -1, n);
    compare_all("post_rst", n);
    check_done("post_rst");

    // Start held high across two back-to-back blocks.
    set_abc();
    start_and_load(-1, 1'b1);
    collect(1'b0, -1, n);
    compare_all("b2b_first", n);
    check_done("b2b_first");
    set_ones();
    start_and_load(-1, 1'b1);
    collect(1'b0, -1, n);
    compare_all("b2b_ones", n);
    for (int t = 0; t < 64; t++) got_ff[t] = got[t];
    S_start_in = 1'b0;
    check_done("b2b_ones");

    foreach (gold_q[i]) begin
      if (gold_q[i].blk_id == 0) check32(gold_q[i].name, got_abc[gold_q[i].t], gold_q[i].w);
      else check32(gold_q[i].name, got_ff[gold_q[i].t], gold_q[i].w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/msg_schedule.md
# msg_schedule

SHA-256 message-schedule expander. Accepts the 16 words of one 512-bit block and streams the 64 schedule words W[0..63] to the compression rounds, one per handshake. New words follow W[t+16] = SIG1(W[t+14]) + W[t+9] + SIG0(W[t+1]) + W[t] (mod 2^32). It uses the existing SIG0/SIG1 sigma blocks.

## Interface

- DATA_WIDTH, 32, schedule word width.
- ROUNDS, 64, schedule words emitted per block.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- S_start_in  input  1  begin a block; sampled only in IDLE.
- S_word_in  input  DATA_WIDTH  block word, big-endian order W[0] first.
- S_word_valid_in  input  1  S_word_in valid.
- D_word_ready_out  output  1  load slot available.
- D_w_out  output  DATA_WIDTH  current schedule word W[t].
- D_w_valid_out  output  1  D_w_out valid.
- S_w_ready_in  input  1  downstream accepts D_w_out.
- D_t_out  output  6  index t of D_w_out (only under MSG_SCHED_ROUND_IDX_EN).
- D_done_out  output  1  one-cycle pulse after W[63] accepted.

## Operation

- States: IDLE, LOAD, EXPAND, DONE. 16×DATA_WIDTH window win[0..15]; 6-bit counter cnt.
- IDLE: S_start_in=1 → LOAD, cnt←0. Otherwise stay.
- LOAD: D_word_ready_out=1. On S_word_valid_in & ready: win[cnt]←S_word_in, cnt++. When word 15 is accepted → EXPAND, cnt←0.
- EXPAND: D_w_out=win[0], D_w_valid_out=1, D_t_out=cnt. On S_w_ready_in: win[i]←win[i+1] for i=0..14; win[15]←SIG1(win[14])+win[9]+SIG0(win[1])+win[0], truncated to DATA_WIDTH; cnt++. When t=ROUNDS-1 is accepted → DONE.
- DONE: D_done_out=1 for exactly one cycle, then IDLE.
- Words computed for t≥48 are never emitted. They are harmless and need no gating.
- S_start_in outside IDLE is ignored. S_word_valid_in outside LOAD is ignored.
- Stall: with S_w_ready_in=0, D_w_out, D_t_out and the window hold unchanged.

## Timing

- Reset values: state=IDLE, cnt=0, win=0, D_w_out=0, all valid/ready/done outputs 0.
- Reset asserted mid-operation aborts the block immediately. Partial data is discarded. No D_done_out is issued.
- All outputs are registered or decoded from state. No combinational input→output path.
- Start latency: S_start_in high at edge N → D_word_ready_out high after edge N.
- First output: D_w_valid_out rises the cycle after the 16th load handshake.
- Throughput is 1 word/cycle in LOAD and in EXPAND. Best case from start to done pulse is 1+16+64+1 cycles.
- Adder chain: SIG1 + SIG0 + 2 adds feed win[15] within one cycle and must meet timing at the target clock.

## Configuration

- MSG_SCHED_ROUND_IDX_EN defined: D_t_out port is present and equals cnt during EXPAND, 0 elsewhere.
- Not defined: D_t_out port is absent. cnt is still implemented internally for sequencing.

## Structure

- Shared package sha256_pkg holds:
  - DATA_WIDTH, WORDS_PER_BLOCK=16, ROUNDS=64;
  - the state encoding constants IDLE/LOAD/EXPAND/DONE.
- One new sub-module, msg_window: 16-word register file with indexed load, shift-by-one, and taps 0/1/9/14.
- SIG0 and SIG1 are instantiated inside msg_schedule as combinational leaves.

## Test plan

- "abc" block: W0=0x61626380, W1..W14=0, W15=0x00000018, S_w_ready_in=1.
  - W0..W15 are echoed in order.
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB.
  - D_done_out pulses once, 82 cycles after start.
- Same block with S_w_ready_in toggled pseudo-randomly: identical word sequence, no duplicates or drops, D_w_out stable during stalls.
- Load with gaps: S_word_valid_in low for 3 cycles between words 7 and 8. The schedule matches the uninterrupted case.
- Reset asserted while emitting t=30:
  - all outputs return to 0 and state to IDLE;
  - a new "abc" block then yields the correct W[0..63].
- S_start_in held high throughout two back-to-back blocks (second block all-0xFFFFFFFF): start is ignored while busy, the second block begins only after DONE, and its W16 matches the golden model.
- With MSG_SCHED_ROUND_IDX_EN: D_t_out runs 0..63, tracking each accepted word. Without the macro, the build passes with the port absent.
